// File: rtl/keypad_hex_entry.sv
// keypad_hex_entry: scans a 4x4 active-low keypad and builds a 4-digit hex entry.
// Define KEYPAD_CMD_KEYS_EN to turn key E into CLEAR and key F into ENTER.
module keypad_hex_entry #(
   parameter int SCAN_DIV_W       = 16,
   parameter int DEBOUNCE_SAMPLES = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  rows,
   output logic [3:0]  cols,
   output logic [15:0] value,
   output logic [3:0]  key_code,
   output logic        key_strobe,
   output logic        entry_done,
   output logic [2:0]  digit_count
);

   typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} state_t;

   localparam logic [3:0] DS = 4'(DEBOUNCE_SAMPLES);

   state_t                state, state_n;
   logic [SCAN_DIV_W-1:0] dwell;
   logic [3:0]            rows_m, rs;
   logic [3:0]            dbc, dbc_n;
   logic [1:0]            col, col_n;
   logic [1:0]            row, row_n;
   logic [1:0]            low_row, acc_row;
   logic [1:0]            idle, idle_n;
   logic                  armed, armed_n;
   logic                  sample, accept;
   logic [3:0]            nib, key_code_n;
   logic [15:0]           value_n;
   logic [2:0]            count_n;
   logic                  strobe_n, done_n;

   function automatic logic [3:0] key_map(input logic [1:0] r,
                                          input logic [1:0] c);
      logic [3:0] k;
      unique case ({r, c})
         4'h0: k = 4'h1;
         4'h1: k = 4'h2;
         4'h2: k = 4'h3;
         4'h3: k = 4'hA;
         4'h4: k = 4'h4;
         4'h5: k = 4'h5;
         4'h6: k = 4'h6;
         4'h7: k = 4'hB;
         4'h8: k = 4'h7;
         4'h9: k = 4'h8;
         4'hA: k = 4'h9;
         4'hB: k = 4'hC;
         4'hC: k = 4'hE;
         4'hD: k = 4'h0;
         4'hE: k = 4'hF;
         4'hF: k = 4'hD;
      endcase
      return k;
   endfunction

   assign cols   = ~(4'b0001 << col);
   assign sample = &dwell;

   always_comb begin
      low_row = 2'd3;
      if (!rs[0])      low_row = 2'd0;
      else if (!rs[1]) low_row = 2'd1;
      else if (!rs[2]) low_row = 2'd2;
   end

   // After reset, a key can only be taken once a full idle rotation is seen,
   // so a key held across reset never registers.
   always_comb begin
      state_n = state;
      dbc_n   = dbc;
      col_n   = col;
      row_n   = row;
      idle_n  = idle;
      armed_n = armed;
      accept  = 1'b0;
      acc_row = row;
      if (sample) begin
         unique case (state)
            SCAN: begin
               if (rs == 4'hF || !armed) col_n = col + 2'd1;
               if (!armed) begin
                  idle_n = (rs == 4'hF) ? idle + 2'd1 : 2'd0;
                  if (rs == 4'hF && idle == 2'd3) armed_n = 1'b1;
               end else if (rs != 4'hF) begin
                  row_n = low_row;
                  dbc_n = 4'd1;
                  if (DS == 4'd1) begin
                     accept  = 1'b1;
                     acc_row = low_row;
                     dbc_n   = 4'd0;
                     state_n = HELD;
                  end else begin
                     state_n = DEBOUNCE;
                  end
               end
            end
            DEBOUNCE: begin
               if (!rs[row]) begin
                  dbc_n = dbc + 4'd1;
                  if (dbc + 4'd1 == DS) begin
                     accept  = 1'b1;
                     dbc_n   = 4'd0;
                     state_n = HELD;
                  end
               end else begin
                  state_n = SCAN;
               end
            end
            HELD: begin
               if (rs == 4'hF) begin
                  dbc_n = dbc + 4'd1;
                  if (dbc + 4'd1 == DS) begin
                     dbc_n   = 4'd0;
                     state_n = SCAN;
                  end
               end else begin
                  dbc_n = 4'd0;
               end
            end
            default: state_n = SCAN;
         endcase
      end
   end

   always_comb begin
      nib        = key_map(acc_row, col);
      key_code_n = key_code;
      value_n    = value;
      count_n    = digit_count;
      strobe_n   = 1'b0;
      done_n     = 1'b0;
      if (accept) begin
         key_code_n = nib;
         strobe_n   = 1'b1;
`ifdef KEYPAD_CMD_KEYS_EN
         if (nib == 4'hE) begin
            value_n = 16'h0000;
            count_n = 3'd0;
         end else if (nib == 4'hF) begin
            if (digit_count != 3'd0) begin
               done_n  = 1'b1;
               count_n = 3'd4;
            end
         end else
`endif
         if (digit_count == 3'd4) begin
            value_n = {12'h000, nib};
            count_n = 3'd1;
         end else begin
            value_n = {value[11:0], nib};
            count_n = digit_count + 3'd1;
            done_n  = (digit_count == 3'd3);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rows_m      <= 4'hF;
         rs          <= 4'hF;
         dwell       <= '0;
         state       <= SCAN;
         dbc         <= 4'd0;
         col         <= 2'd0;
         row         <= 2'd0;
         idle        <= 2'd0;
         armed       <= 1'b0;
         value       <= 16'h0000;
         key_code    <= 4'h0;
         key_strobe  <= 1'b0;
         entry_done  <= 1'b0;
         digit_count <= 3'd0;
      end else begin
         rows_m      <= rows;
         rs          <= rows_m;
         dwell       <= dwell + SCAN_DIV_W'(1);
         state       <= state_n;
         dbc         <= dbc_n;
         col         <= col_n;
         row         <= row_n;
         idle        <= idle_n;
         armed       <= armed_n;
         value       <= value_n;
         key_code    <= key_code_n;
         key_strobe  <= strobe_n;
         entry_done  <= done_n;
         digit_count <= count_n;
      end
   end

endmodule

// File: tb/tb_keypad_hex_entry.sv
// tb_keypad_hex_entry: random key entry against a digit-queue reference model.
// Keypad is modelled as a switch matrix driven from the DUT column lines.
module tb_keypad_hex_entry;

   localparam int DWELL   = 4;
   localparam int DS      = 3;
   localparam int LAT     = 3 + (DS - 1) * DWELL + 1;
   localparam int RELEASE = DWELL * (DS + 3);

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [3:0]  rows;
   logic [3:0]  cols;
   logic [15:0] value;
   logic [3:0]  key_code;
   logic        key_strobe;
   logic        entry_done;
   logic [2:0]  digit_count;

   logic        pressed = 1'b0;
   logic [1:0]  kr = 2'd0;
   logic [1:0]  kc = 2'd0;
   logic        manual = 1'b0;
   logic [3:0]  man_rows = 4'hF;

   int n_vec = 0;
   int n_bad = 0;
   int t = 0;
   int n_strobe = 0;
   int n_done = 0;
   int last_strobe_t = -1;
   logic prev_ks = 1'b0;

   logic [3:0] KM [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                           4'h4, 4'h5, 4'h6, 4'hB,
                           4'h7, 4'h8, 4'h9, 4'hC,
                           4'hE, 4'h0, 4'hF, 4'hD};

   logic [3:0] q[$];
   bit         entered = 0;

   keypad_hex_entry #(
      .SCAN_DIV_W       (2),
      .DEBOUNCE_SAMPLES (DS)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .rows        (rows),
      .cols        (cols),
      .value       (value),
      .key_code    (key_code),
      .key_strobe  (key_strobe),
      .entry_done  (entry_done),
      .digit_count (digit_count)
   );

   assign rows = manual ? man_rows :
                 (pressed && !cols[kc]) ? ~(4'b0001 << kr) : 4'hF;

   always #5 clk = ~clk;

   always @(posedge clk) t <= reset ? 0 : t + 1;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h (t=%0d)", tag, got, exp, t);
      end
   endtask

   always @(negedge clk) begin
      if (key_strobe) begin
         chk("strobe_pulse", prev_ks, 0);
         n_strobe++;
         last_strobe_t = t;
      end
      if (entry_done) begin
         chk("done_w_strobe", key_strobe, 1);
         n_done++;
      end
      prev_ks = key_strobe;
   end

   function automatic logic [15:0] model_value();
      logic [15:0] v = 16'h0000;
      foreach (q[i]) v = (v << 4) | 16'(q[i]);
      return v;
   endfunction

   function automatic int model_count();
      return entered ? 4 : q.size();
   endfunction

   task automatic model_key(input logic [3:0] k, output int done);
      done = 0;
`ifdef KEYPAD_CMD_KEYS_EN
      if (k == 4'hE) begin
         q.delete();
         entered = 0;
         return;
      end
      if (k == 4'hF) begin
         if (q.size() > 0) begin
            done = 1;
            entered = 1;
         end
         return;
      end
`endif
      if (q.size() == 4 || entered) begin
         q.delete();
         entered = 0;
      end
      q.push_back(k);
      if (q.size() == 4) done = 1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      q.delete();
      entered = 0;
   endtask

   task automatic align_col(input logic [1:0] c);
      bit ok = 0;
      for (int i = 0; i < 64 && !ok; i++) begin
         @(negedge clk);
         if (!cols[c] && t % DWELL == 0) ok = 1;
      end
      chk("align", ok, 1);
   endtask

   task automatic press_key(input logic [3:0] k);
      int idx = 0;
      int t0, s0, d0, exp_done;
      for (int i = 0; i < 16; i++) if (KM[i] == k) idx = i;
      kr = 2'(idx / 4);
      kc = 2'(idx % 4);
      align_col(kc);
      t0 = t;
      s0 = n_strobe;
      d0 = n_done;
      pressed = 1'b1;
      repeat (LAT + 4) @(negedge clk);
      chk("latency", last_strobe_t, t0 + LAT);
      pressed = 1'b0;
      repeat (RELEASE) @(negedge clk);
      model_key(k, exp_done);
      chk("strobes", n_strobe - s0, 1);
      chk("key_code", key_code, k);
      chk("value", value, model_value());
      chk("count", digit_count, model_count());
      chk("done", n_done - d0, exp_done);
   endtask

   initial begin
      logic [3:0] ec, a, b;
      int s0, d0;

      do_reset();
      chk("rst_value", value, 0);
      chk("rst_key_code", key_code, 0);
      chk("rst_count", digit_count, 0);
      chk("rst_strobe", key_strobe, 0);
      chk("rst_done", entry_done, 0);
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         ec = ~(4'b0001 << ((t / DWELL) % 4));
         chk("scan_cols", cols, ec);
      end
      chk("idle_strobes", n_strobe, 0);
      chk("idle_value", value, 0);

      press_key(4'h5);
      chk("v0005", value, 16'h0005);

      do_reset();
      repeat (30) @(negedge clk);
      press_key(4'h1);
      press_key(4'h2);
      press_key(4'h3);
      press_key(4'hA);
      chk("v123A", value, 16'h123A);
      press_key(4'h7);
      chk("v0007", value, 16'h0007);
      chk("c1", digit_count, 1);

      // contact bounce: low, high, low sample on row 0
      s0 = n_strobe;
      align_col(2'd0);
      manual = 1'b1;
      man_rows = 4'b1110;
      repeat (DWELL) @(negedge clk);
      man_rows = 4'hF;
      repeat (DWELL) @(negedge clk);
      man_rows = 4'b1110;
      repeat (DWELL) @(negedge clk);
      man_rows = 4'hF;
      repeat (2 * DWELL) @(negedge clk);
      manual = 1'b0;
      chk("bounce_strobes", n_strobe - s0, 0);
      align_col(2'd1);
      a = cols;
      repeat (DWELL) @(negedge clk);
      b = cols;
      chk("bounce_rotate", b, {a[2:0], a[3]});

      // reset while key 9 is in debounce, key kept down
      kr = 2'd2;
      kc = 2'd2;
      align_col(kc);
      pressed = 1'b1;
      repeat (6) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      q.delete();
      entered = 0;
      s0 = n_strobe;
      d0 = n_done;
      repeat (60) @(negedge clk);
      chk("hold_rst_strobes", n_strobe - s0, 0);
      chk("hold_rst_done", n_done - d0, 0);
      chk("hold_rst_value", value, 0);
      chk("hold_rst_count", digit_count, 0);
      chk("hold_rst_code", key_code, 0);
      pressed = 1'b0;
      repeat (30) @(negedge clk);
      press_key(4'h9);

      for (int i = 0; i < 20; i++) press_key(4'($urandom_range(0, 15)));

`ifdef KEYPAD_CMD_KEYS_EN
      do_reset();
      repeat (30) @(negedge clk);
      press_key(4'h4);
      press_key(4'h2);
      d0 = n_done;
      press_key(4'hF);
      chk("cmd_enter_done", n_done - d0, 1);
      chk("cmd_v0042", value, 16'h0042);
      press_key(4'hE);
      chk("cmd_clear_value", value, 0);
      chk("cmd_clear_count", digit_count, 0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

endmodule
